// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes, swallows Pause, filters typematic repeats,
// tracks shift/caps and queues {ext,brk,scan} key events in a small valid/ready FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  input  logic       byte_err_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [9:0] evt_code_o,
  output logic       shift_o,
  output logic       caps_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [8:0]    held_q, held_d;
  logic          held_v_q, held_v_d;
  logic          shl_q, shl_d, shr_q, shr_d;
  logic          caps_q, caps_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;

  logic       emit, evt_ext, evt_brk, is_pause, is_prefix;
  logic [7:0] evt_scan;
  logic [8:0] key;
  logic       make, suppress, push, pop, full, push_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    evt_ext   = 1'b0;
    evt_brk   = 1'b0;
    evt_scan  = byte_data_i;
    is_pause  = 1'b0;
    is_prefix = (byte_data_i == 8'hE0) || (byte_data_i == 8'hF0) || (byte_data_i == 8'hE1);
    if (byte_valid_i) begin
      if (byte_err_i) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end else if (state_q == SKIP) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d  = IDLE;
          cnt_d    = 3'd0;
          emit     = (cnt_q == 3'd1);
          evt_ext  = 1'b1;
          evt_scan = 8'hE1;
          is_pause = 1'b1;
        end
      end else if (state_q == EXT && byte_data_i == 8'hF0) begin
        state_d = EXT_BRK;
      end else if (state_q == IDLE || is_prefix) begin
        // A prefix arriving mid-sequence restarts decoding from IDLE
        case (byte_data_i)
          8'hE0: state_d = EXT;
          8'hF0: state_d = BRK;
          8'hE1: begin
            state_d = SKIP;
            cnt_d   = 3'd7;
          end
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = IDLE;
          default: begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        endcase
      end else begin
        emit    = 1'b1;
        evt_ext = (state_q == EXT) || (state_q == EXT_BRK);
        evt_brk = (state_q == BRK) || (state_q == EXT_BRK);
        state_d = IDLE;
      end
    end
  end

  assign key      = {evt_ext, evt_scan};
  assign make     = !evt_brk;
  assign suppress = REPEAT_FILTER && !is_pause && make && held_v_q && (held_q == key);

  always_comb begin
    held_d   = held_q;
    held_v_d = held_v_q;
    shl_d    = shl_q;
    shr_d    = shr_q;
    caps_d   = caps_q;
    if (emit && !is_pause) begin
      if (REPEAT_FILTER) begin
        if (make && !suppress) begin
          held_d   = key;
          held_v_d = 1'b1;
        end else if (!make && key == held_q) begin
          held_v_d = 1'b0;
        end
      end
      if (key == 9'h012) shl_d = make;
      if (key == 9'h059) shr_d = make;
      if (make && !suppress && key == 9'h058) caps_d = !caps_q;
    end
  end

  assign evt_valid_o = (wptr_q != rptr_q);
  assign full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop         = evt_valid_o && evt_ready_i;
  assign push        = emit && !suppress;
  assign push_ok     = push && (!full || pop);
  assign overflow_d  = overflow_q || (push && !push_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      held_q     <= 9'd0;
      held_v_q   <= 1'b0;
      shl_q      <= 1'b0;
      shr_q      <= 1'b0;
      caps_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_v_q   <= held_v_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      caps_q     <= caps_d;
      overflow_q <= overflow_d;
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= {evt_ext, evt_brk, evt_scan};
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (pop) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  assign evt_code_o = evt_valid_o ? mem_q[rptr_q[AW-1:0]] : 10'd0;
  assign shift_o    = shl_q || shr_q;
  assign caps_o     = caps_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: one instance with the repeat filter on, one with it off,
// driven by a shared byte stream and checked against hand-computed vectors.
module tb_ps2_key_decoder;

  logic       clk, rst, byte_valid, byte_err, evt_ready;
  logic [7:0] byte_data;
  logic       evt_valid, shift, caps, overflow;
  logic [9:0] evt_code;
  logic       evt_valid0, shift0, caps0, overflow0;
  logic [9:0] evt_code0;

  int nApplied = 0;
  int nMiss    = 0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_err_i(byte_err), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_code_o(evt_code), .shift_o(shift), .caps_o(caps), .overflow_o(overflow));

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_err_i(byte_err), .evt_valid_o(evt_valid0), .evt_ready_i(evt_ready),
    .evt_code_o(evt_code0), .shift_o(shift0), .caps_o(caps0), .overflow_o(overflow0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [9:0] c;
    logic [9:0] c0;
    logic       s;
    logic       k;
    logic       k0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] d, input logic e, input logic [9:0] c,
                              input logic [9:0] c0, input logic s, input logic k, input logic k0);
    vec_t v;
    v.data = d; v.err = e; v.c = c; v.c0 = c0; v.s = s; v.k = k; v.k0 = k0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Strobe one byte, then return 1 time unit after the edge that consumed it
  task automatic applyStimulus(input logic [7:0] d, input logic e);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_err   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [9:0] drainExp [4];

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_err = 1'b0; byte_data = 8'h00; evt_ready = 1'b1;

    // filter-on code, filter-off code, shift, caps (filter on), caps (filter off)
    vecs.push_back(mk(8'h1C, 0, 10'h01C, 10'h01C, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h11C, 10'h11C, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h75, 0, 10'h275, 10'h275, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h75, 0, 10'h375, 10'h375, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h01C, 10'h01C, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h000, 10'h01C, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h000, 10'h01C, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h11C, 10'h11C, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 10'h012, 10'h012, 1, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 10'h01C, 10'h01C, 1, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 1, 0, 0));
    vecs.push_back(mk(8'h12, 0, 10'h112, 10'h112, 0, 0, 0));
    vecs.push_back(mk(8'h59, 0, 10'h059, 10'h059, 1, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 1, 0, 0));
    vecs.push_back(mk(8'h59, 0, 10'h159, 10'h159, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 10'h212, 10'h212, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 10'h312, 10'h312, 0, 0, 0));
    vecs.push_back(mk(8'h58, 0, 10'h058, 10'h058, 0, 1, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 1, 1));
    vecs.push_back(mk(8'h58, 0, 10'h158, 10'h158, 0, 1, 1));
    vecs.push_back(mk(8'h58, 0, 10'h058, 10'h058, 0, 0, 0));
    vecs.push_back(mk(8'h58, 0, 10'h000, 10'h058, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h58, 0, 10'h158, 10'h158, 0, 0, 1));
    vecs.push_back(mk(8'hE1, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h14, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h77, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hE1, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h14, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h77, 0, 10'h2E1, 10'h2E1, 0, 0, 1));
    vecs.push_back(mk(8'hE0, 1, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h1C, 0, 10'h01C, 10'h01C, 0, 0, 1));
    vecs.push_back(mk(8'hAA, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hFA, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h00, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h75, 0, 10'h275, 10'h275, 0, 0, 1));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hE0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h75, 0, 10'h375, 10'h375, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h1C, 1, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h1C, 0, 10'h01C, 10'h01C, 0, 0, 1));
    vecs.push_back(mk(8'hE1, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h14, 1, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(8'h2A, 0, 10'h02A, 10'h02A, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset evt_valid", {9'd0, evt_valid}, 10'd0);
    checkOutput("reset evt_code", evt_code, 10'd0);
    checkOutput("reset shift", {9'd0, shift}, 10'd0);
    checkOutput("reset caps", {9'd0, caps}, 10'd0);
    checkOutput("reset overflow", {9'd0, overflow}, 10'd0);

    // Each event must be visible exactly one cycle after its final byte
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].err);
      checkOutput($sformatf("v%0d evt_valid", i), {9'd0, evt_valid}, {9'd0, vecs[i].c != 10'd0});
      if (vecs[i].c != 10'd0) checkOutput($sformatf("v%0d evt_code", i), evt_code, vecs[i].c);
      checkOutput($sformatf("v%0d nofilt evt_valid", i), {9'd0, evt_valid0}, {9'd0, vecs[i].c0 != 10'd0});
      if (vecs[i].c0 != 10'd0) checkOutput($sformatf("v%0d nofilt evt_code", i), evt_code0, vecs[i].c0);
      checkOutput($sformatf("v%0d shift", i), {9'd0, shift}, {9'd0, vecs[i].s});
      checkOutput($sformatf("v%0d caps", i), {9'd0, caps}, {9'd0, vecs[i].k});
      checkOutput($sformatf("v%0d nofilt caps", i), {9'd0, caps0}, {9'd0, vecs[i].k0});
      idleCycle();
    end

    // Overflow: six keystrokes into a depth-4 FIFO with the consumer stalled
    @(negedge clk);
    evt_ready = 1'b0;
    drainExp[0] = 10'h015; drainExp[1] = 10'h01D; drainExp[2] = 10'h024; drainExp[3] = 10'h02D;
    applyStimulus(8'h15, 0); idleCycle();
    applyStimulus(8'h1D, 0); idleCycle();
    applyStimulus(8'h24, 0); idleCycle();
    applyStimulus(8'h2D, 0); idleCycle();
    checkOutput("full no overflow yet", {9'd0, overflow}, 10'd0);
    applyStimulus(8'h2C, 0); idleCycle();
    applyStimulus(8'h35, 0); idleCycle();
    checkOutput("overflow", {9'd0, overflow}, 10'd1);
    checkOutput("nofilt overflow", {9'd0, overflow0}, 10'd1);
    checkOutput("stall evt_valid", {9'd0, evt_valid}, 10'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall evt_code", evt_code, 10'h015);
    @(negedge clk);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d evt_valid", i), {9'd0, evt_valid}, 10'd1);
      checkOutput($sformatf("drain%0d evt_code", i), evt_code, drainExp[i]);
      checkOutput($sformatf("drain%0d nofilt evt_code", i), evt_code0, drainExp[i]);
      @(posedge clk);
      #1;
    end
    checkOutput("drained evt_valid", {9'd0, evt_valid}, 10'd0);
    checkOutput("overflow sticky", {9'd0, overflow}, 10'd1);

    // Reset in the middle of a break sequence
    applyStimulus(8'h58, 0);
    checkOutput("pre-reset evt_code", evt_code, 10'h058);
    checkOutput("pre-reset caps", {9'd0, caps}, 10'd1);
    idleCycle();
    applyStimulus(8'hF0, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-reset evt_valid", {9'd0, evt_valid}, 10'd0);
    checkOutput("mid-reset overflow", {9'd0, overflow}, 10'd0);
    checkOutput("mid-reset caps", {9'd0, caps}, 10'd0);
    checkOutput("mid-reset nofilt caps", {9'd0, caps0}, 10'd0);
    applyStimulus(8'h1C, 0);
    checkOutput("post-reset evt_valid", {9'd0, evt_valid}, 10'd1);
    checkOutput("post-reset evt_code", evt_code, 10'h01C);
    checkOutput("post-reset nofilt evt_code", evt_code0, 10'h01C);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
